// File: rtl/dmux4_stream.sv
// Registered 1-to-4 stream demultiplexer: each output channel owns a
// 2-entry FIFO so a stalled consumer only backs up its own channel.
module dmux4_stream #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [4*WIDTH-1:0] out_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [7:0]         out_level
);

   logic [1:0] level_w [4];
   logic [3:0] push_w;

   // Ready depends only on the selected channel's registered occupancy.
   assign in_ready = (level_w[in_sel] != 2'd2);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_chan
         logic [1:0]       count_q, count_d;
         logic [WIDTH-1:0] head_q, head_d;
         logic [WIDTH-1:0] tail_q, tail_d;
         logic             pop_w;

         assign push_w[gi] = in_valid && in_ready && (in_sel == 2'(gi));
         assign pop_w      = (count_q != 2'd0) && out_ready[gi];

         always_comb begin
            count_d = count_q;
            head_d  = head_q;
            tail_d  = tail_q;
            case (count_q)
               2'd0: begin
                  if (push_w[gi]) begin
                     count_d = 2'd1;
                     head_d  = in_data;
                  end
               end
               2'd1: begin
                  if (push_w[gi] && pop_w) begin
                     head_d = in_data;
                  end else if (push_w[gi]) begin
                     count_d = 2'd2;
                     tail_d  = in_data;
                  end else if (pop_w) begin
                     count_d = 2'd0;
                     head_d  = '0;
                  end
               end
               2'd2: begin
                  // A full channel never sees a push, since in_ready is low for it.
                  if (pop_w) begin
                     count_d = 2'd1;
                     head_d  = tail_q;
                     tail_d  = '0;
                  end
               end
               default: begin
                  count_d = 2'd0;
                  head_d  = '0;
                  tail_d  = '0;
               end
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               count_q <= 2'd0;
               head_q  <= '0;
               tail_q  <= '0;
            end else begin
               count_q <= count_d;
               head_q  <= head_d;
               tail_q  <= tail_d;
            end
         end

         assign level_w[gi]                  = count_q;
         assign out_level[2*gi +: 2]         = count_q;
         assign out_valid[gi]                = (count_q != 2'd0);
         assign out_data[gi*WIDTH +: WIDTH]  = head_q;
      end
   endgenerate

endmodule

// File: tb/tb_dmux4_stream.sv
// Self-checking bench for dmux4_stream: directed scenarios plus random
// traffic, compared against a per-channel queue model.
module tb_dmux4_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [7:0]  out_level;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] mq      [4][$];
   logic [15:0] dut_got [4][$];

   dmux4_stream #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_level (out_level)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running exp finished");
      $fatal(1, "timeout");
   end

   // Expected {in_ready, out_valid, out_level, out_data} from the queue model.
   function automatic logic [76:0] exp_all();
      logic [3:0]  v;
      logic [7:0]  l;
      logic [63:0] d;
      logic        r;
      for (int k = 0; k < 4; k++) begin
         v[k]         = (mq[k].size() != 0);
         l[2*k +: 2]  = 2'(mq[k].size());
         d[16*k +: 16] = (mq[k].size() != 0) ? mq[k][0] : 16'h0;
      end
      r = (mq[in_sel].size() != 2);
      return {r, v, l, d};
   endfunction

   function automatic logic [76:0] dut_all();
      return {in_ready, out_valid, out_level, out_data};
   endfunction

   // Advance one clock, updating the model and recording DUT pops.
   task automatic step();
      logic       do_push;
      logic [3:0] do_pop;
      logic [1:0] s;
      logic [15:0] d;
      do_push = rst_n && in_valid && (mq[in_sel].size() != 2);
      for (int k = 0; k < 4; k++) begin
         do_pop[k] = rst_n && (mq[k].size() != 0) && out_ready[k];
         if (out_valid[k] && out_ready[k]) dut_got[k].push_back(out_data[16*k +: 16]);
      end
      s = in_sel;
      d = in_data;
      @(posedge clk);
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) mq[k].delete();
      end else begin
         for (int k = 0; k < 4; k++) if (do_pop[k]) void'(mq[k].pop_front());
         if (do_push) mq[s].push_back(d);
      end
      #1;
   endtask

   task automatic clear_got();
      for (int k = 0; k < 4; k++) dut_got[k].delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid  = 1'($urandom);
         in_sel    = 2'($urandom);
         in_data   = 16'($urandom);
         out_ready = 4'($urandom);
         #1;
         tests_run++;
         if (dut_all() !== {1'b1, 76'b0}) begin
            tests_failed++;
            $display("FAIL reset_hold got %h exp %h", dut_all(), {1'b1, 76'b0});
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 4'($urandom);
      #2 rst_n = 1'b1;
      step();
      step();
      tests_run++;
      if (dut_all() !== {1'b1, 76'b0} || dut_got[0].size() + dut_got[1].size() +
          dut_got[2].size() + dut_got[3].size() != 0) begin
         tests_failed++;
         $display("FAIL reset_release got %h exp %h", dut_all(), {1'b1, 76'b0});
      end
      $display("[TB] reset done");
   endtask

   task automatic test_single_route();
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_data   = 16'h1234;
      #1 step();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 4'b0100 || out_data !== 64'h0000_1234_0000_0000 || out_level !== 8'b00_01_00_00) begin
         tests_failed++;
         $display("FAIL single_route got v=%b d=%h l=%b exp v=0100 d=0000123400000000 l=00010000",
                  out_valid, out_data, out_level);
      end
      out_ready = 4'b0100;
      #1 step();
      out_ready = 4'b0000;
      #1;
      tests_run++;
      if (out_valid !== 4'b0000 || out_data !== 64'h0) begin
         tests_failed++;
         $display("FAIL single_pop got v=%b d=%h exp v=0000 d=0", out_valid, out_data);
      end
      $display("[TB] single route sel=2 data=1234 done");
   endtask

   task automatic test_backpressure();
      clear_got();
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd1;
      in_data   = 16'hAAAA;
      #1 step();
      in_data = 16'hBBBB;
      #1 step();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || out_level[3:2] !== 2'd2) begin
         tests_failed++;
         $display("FAIL bp_full got ready=%b lvl=%0d exp ready=0 lvl=2", in_ready, out_level[3:2]);
      end
      in_sel = 2'd0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_other_sel got ready=%b exp 1", in_ready);
      end
      out_ready = 4'b0010;
      #1 step();
      step();
      out_ready = 4'b0000;
      #1;
      tests_run++;
      if (dut_got[1].size() != 2 || out_valid[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_drain_count got n=%0d v=%b exp n=2 v=0", dut_got[1].size(), out_valid[1]);
      end else begin
         tests_run++;
         if (dut_got[1][0] !== 16'hAAAA || dut_got[1][1] !== 16'hBBBB) begin
            tests_failed++;
            $display("FAIL bp_order got %h,%h exp aaaa,bbbb", dut_got[1][0], dut_got[1][1]);
         end
      end
      $display("[TB] backpressure sel=1 done");
   endtask

   task automatic test_push_pop();
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd3;
      in_data   = 16'h0001;
      #1 step();
      out_ready = 4'b1000;
      in_data   = 16'h0002;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL pp_ready got %b exp 1", in_ready);
      end
      step();
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      #1;
      tests_run++;
      if (out_level[7:6] !== 2'd1 || out_data[63:48] !== 16'h0002) begin
         tests_failed++;
         $display("FAIL push_pop got lvl=%0d head=%h exp lvl=1 head=0002", out_level[7:6], out_data[63:48]);
      end
      out_ready = 4'b1000;
      #1 step();
      out_ready = 4'b0000;
      $display("[TB] push+pop at count 1 done");
   endtask

   task automatic test_independence();
      logic [15:0] sent [4][$];
      logic [15:0] a0;
      clear_got();
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      for (int i = 0; i < 2; i++) begin
         in_data = 16'($urandom);
         if (i == 0) a0 = in_data;
         #1 step();
      end
      out_ready = 4'b1110;
      for (int i = 0; i < 30; i++) begin
         in_sel  = 2'(1 + i % 3);
         in_data = 16'($urandom);
         sent[in_sel].push_back(in_data);
         #1;
         tests_run++;
         if (dut_all() !== exp_all() || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL indep_cycle%0d got %h exp %h", i, dut_all(), exp_all());
         end
         step();
      end
      in_valid = 1'b0;
      #1 step();
      step();
      for (int k = 1; k < 4; k++) begin
         tests_run++;
         if (dut_got[k] != sent[k]) begin
            tests_failed++;
            $display("FAIL indep_order ch%0d got n=%0d exp n=%0d", k, dut_got[k].size(), sent[k].size());
         end
      end
      tests_run++;
      if (out_level !== 8'b00_00_00_10 || out_data[15:0] !== a0) begin
         tests_failed++;
         $display("FAIL indep_a_hold got lvl=%b head=%h exp lvl=00000010 head=%h", out_level, out_data[15:0], a0);
      end
      out_ready = 4'b0001;
      #1 step();
      step();
      out_ready = 4'b0000;
      $display("[TB] independence 30 words done");
   endtask

   task automatic test_async_reset();
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_sel  = 2'(i / 2);
         in_data = 16'($urandom);
         #1 step();
      end
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_level !== 8'hAA) begin
         tests_failed++;
         $display("FAIL ar_full got %h exp aa", out_level);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (dut_all() !== {1'b1, 76'b0}) begin
         tests_failed++;
         $display("FAIL ar_clear got %h exp %h", dut_all(), {1'b1, 76'b0});
      end
      for (int k = 0; k < 4; k++) mq[k].delete();
      #1 rst_n = 1'b1;
      in_valid = 1'b1;
      in_sel   = 2'd0;
      in_data  = 16'h5555;
      #1 step();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 4'b0001 || out_data !== 64'h5555 || out_level !== 8'h01) begin
         tests_failed++;
         $display("FAIL ar_post got v=%b d=%h l=%h exp v=0001 d=5555 l=01", out_valid, out_data, out_level);
      end
      out_ready = 4'b0001;
      #1 step();
      out_ready = 4'b0000;
      $display("[TB] async reset mid-operation done");
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom);
         in_data   = 16'($urandom);
         out_ready = 4'($urandom);
         #1;
         tests_run++;
         if (dut_all() !== exp_all()) begin
            tests_failed++;
            errs++;
            if (errs < 10) $display("FAIL random_cycle%0d got %h exp %h", i, dut_all(), exp_all());
         end
         step();
      end
      $display("[TB] random 400 cycles done");
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = 16'h0;
      out_ready = 4'b0;
      test_reset();
      test_single_route();
      test_backpressure();
      test_push_pop();
      test_independence();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
